// File: rtl/pipeline_issue_if.sv
// Command and request channels between the issue head-end and pipeline stage 0.
// cmd: a burst is taken on a cycle with cmd_valid=1 and cmd_ready=1. out: a request transfers on out_valid=1 and in_stall=0.
interface pipeline_issue_if #(
   parameter int ADDR_W = 16,
   parameter int ID_W   = 4,
   parameter int LEN_W  = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [ADDR_W-1:0] cmd_address;
   logic [ADDR_W-1:0] cmd_stride;
   logic [LEN_W-1:0]  cmd_length;
   logic [ADDR_W-1:0] out_address;
   logic [ID_W-1:0]   out_id;
   logic              out_valid;
   logic              in_stall;
   logic              out_flush;
   logic [ID_W-1:0]   out_flush_id;

   modport master (
      input  cmd_valid, cmd_address, cmd_stride, cmd_length, in_stall,
      output cmd_ready, out_address, out_id, out_valid, out_flush, out_flush_id
   );

   modport slave (
      output cmd_valid, cmd_address, cmd_stride, cmd_length, in_stall,
      input  cmd_ready, out_address, out_id, out_valid, out_flush, out_flush_id
   );
endinterface

// File: rtl/pipeline_issue.sv
// Address pipeline head-end: issues a strided burst with wrapping IDs, tracks
// outstanding IDs in a bitmap and originates the flush broadcast on redirect.
module pipeline_issue #(
   parameter int ADDR_W = 16,
   parameter int ID_W   = 4,
   parameter int LEN_W  = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   pipeline_issue_if.master      bus,
   input  logic                  redirect_valid,
   input  logic [ID_W-1:0]       redirect_id,
   input  logic [ADDR_W-1:0]     redirect_address,
   input  logic                  ret_valid,
   input  logic [ID_W-1:0]       ret_id,
   output logic                  busy,
   output logic                  done,
   output logic                  err_retire,
   output logic [1:0]            state
);
   localparam int NID = 1 << ID_W;

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, FLUSH = 2'd2, WAIT = 2'd3} state_t;

   state_t            state_q, state_d;
   logic [NID-1:0]    bitmap_q, bitmap_d;
   logic [ID_W-1:0]   next_id_q, next_id_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] stride_q, stride_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;
   logic              valid_q, valid_d;
   logic              flush_q, flush_d;
   logic [ID_W-1:0]   flush_id_q, flush_id_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              busy_q, ready_q;
   logic              take_cmd, take_redirect, xfer;

   // Redirect wins over a same-cycle transfer, so the held request is never consumed.
   assign take_cmd      = (state_q == IDLE) && bus.cmd_valid;
   assign take_redirect = redirect_valid && ((state_q == ISSUE) || (state_q == WAIT));
   assign xfer          = (state_q == ISSUE) && valid_q && !bus.in_stall && !redirect_valid;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (bus.cmd_valid) state_d = (bus.cmd_length != '0) ? ISSUE : WAIT;
         ISSUE: begin
            if (redirect_valid)                              state_d = FLUSH;
            else if (xfer && (remaining_q == LEN_W'(1)))     state_d = WAIT;
         end
         FLUSH: state_d = (remaining_q != '0) ? ISSUE : WAIT;
         WAIT: begin
            if (redirect_valid)      state_d = FLUSH;
            else if (bitmap_q == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bitmap_d    = bitmap_q;
      next_id_d   = next_id_q;
      addr_d      = addr_q;
      stride_d    = stride_q;
      remaining_d = remaining_q;
      flush_d     = 1'b0;
      flush_id_d  = flush_id_q;
      err_d       = err_q;
      if (take_cmd) begin
         addr_d      = bus.cmd_address;
         stride_d    = bus.cmd_stride;
         remaining_d = bus.cmd_length;
      end
      if (xfer) begin
         bitmap_d[next_id_q] = 1'b1;
         next_id_d           = next_id_q + ID_W'(1);
         addr_d              = addr_q + stride_q;
         remaining_d         = remaining_q - LEN_W'(1);
      end
      if (take_redirect) begin
         addr_d                = redirect_address;
         bitmap_d[redirect_id] = 1'b0;
         flush_d               = 1'b1;
         flush_id_d            = redirect_id;
      end
      // A retire racing a flush of the same ID is not an error.
      if (ret_valid) begin
         if (!bitmap_q[ret_id] && !(take_redirect && (redirect_id == ret_id))) err_d = 1'b1;
         bitmap_d[ret_id] = 1'b0;
      end
      done_d  = (state_q == WAIT) && (state_d == IDLE);
      valid_d = (state_d == ISSUE) && (remaining_d != '0) && !bitmap_d[next_id_d];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bitmap_q    <= '0;
         next_id_q   <= '0;
         addr_q      <= '0;
         stride_q    <= '0;
         remaining_q <= '0;
         valid_q     <= 1'b0;
         flush_q     <= 1'b0;
         flush_id_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         ready_q     <= 1'b1;
      end else begin
         bitmap_q    <= bitmap_d;
         next_id_q   <= next_id_d;
         addr_q      <= addr_d;
         stride_q    <= stride_d;
         remaining_q <= remaining_d;
         valid_q     <= valid_d;
         flush_q     <= flush_d;
         flush_id_q  <= flush_id_d;
         done_q      <= done_d;
         err_q       <= err_d;
         busy_q      <= (state_d != IDLE);
         ready_q     <= (state_d == IDLE);
      end
   end

   // The presented request is simply the current pointer and ID, so a stall holds it for free.
   assign bus.out_address  = addr_q;
   assign bus.out_id       = next_id_q;
   assign bus.out_valid    = valid_q;
   assign bus.out_flush    = flush_q;
   assign bus.out_flush_id = flush_id_q;
   assign bus.cmd_ready    = ready_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign err_retire       = err_q;
   assign state            = state_q;
endmodule

// File: tb/tb_pipeline_issue.sv
// Randomized bench for pipeline_issue: a transaction-level model predicts every
// request (address, id), flush and retire error, and bursts must drain with one done.
module tb_pipeline_issue;
   localparam int ADDR_W = 16;
   localparam int ID_W   = 4;
   localparam int LEN_W  = 8;
   localparam int NID    = 1 << ID_W;
   localparam int QW     = ADDR_W + ID_W;

   // clock / reset
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   pipeline_issue_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

   logic              redirect_valid;
   logic [ID_W-1:0]   redirect_id;
   logic [ADDR_W-1:0] redirect_address;
   logic              ret_valid;
   logic [ID_W-1:0]   ret_id;
   logic              busy, done, err_retire;
   logic [1:0]        state;

   pipeline_issue #(.ADDR_W(ADDR_W), .ID_W(ID_W), .LEN_W(LEN_W)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .bus              (bus),
      .redirect_valid   (redirect_valid),
      .redirect_id      (redirect_id),
      .redirect_address (redirect_address),
      .ret_valid        (ret_valid),
      .ret_id           (ret_id),
      .busy             (busy),
      .done             (done),
      .err_retire       (err_retire),
      .state            (state)
   );

   // scoreboard / model state
   logic [QW-1:0]     exp_q[$];
   logic [NID-1:0]    mdl_out;
   logic [ID_W-1:0]   mdl_next_id;
   logic              mdl_err, mdl_busy, flush_exp, prev_hold;
   logic [ADDR_W-1:0] cur_stride;
   int                cur_len;
   int                ret_due[NID];
   int                ret_lo, ret_hi, stall_pct, redirect_pct;
   int                now, cmd_tick, first_xfer, last_xfer, done_cnt;
   logic [ADDR_W-1:0] xfer_addr[$];
   logic [ID_W-1:0]   xfer_id[$];
   int                n_tests, n_fail;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      mdl_out     = '0;
      mdl_next_id = '0;
      mdl_err     = 1'b0;
      mdl_busy    = 1'b0;
      flush_exp   = 1'b0;
      prev_hold   = 1'b0;
      for (int i = 0; i < NID; i++) ret_due[i] = -1;
   endtask

   // A burst is the list base + k*stride with consecutive ids from the running id counter.
   task automatic model_cmd(input logic [ADDR_W-1:0] base, input logic [ADDR_W-1:0] stride,
                            input int len);
      logic [ADDR_W-1:0] a;
      logic [ID_W-1:0]   id;
      for (int k = 0; k < len; k++) begin
         a  = base + ADDR_W'(k) * stride;
         id = mdl_next_id + ID_W'(k);
         exp_q.push_back({a, id});
      end
      mdl_next_id = mdl_next_id + ID_W'(len);
   endtask

   // A redirect keeps the pending ids but rebases their addresses.
   task automatic model_redirect(input logic [ADDR_W-1:0] raddr);
      int              n;
      logic [ID_W-1:0] id0;
      logic [ADDR_W-1:0] a;
      n   = exp_q.size();
      id0 = (n > 0) ? exp_q[0][ID_W-1:0] : '0;
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
         a = raddr + ADDR_W'(k) * cur_stride;
         exp_q.push_back({a, ID_W'(id0 + ID_W'(k))});
      end
   endtask

   // driver: default per-cycle inputs
   task automatic auto_inputs();
      bus.in_stall   = ($urandom_range(0, 99) < stall_pct);
      redirect_valid = 1'b0;
      ret_valid      = 1'b0;
      for (int i = 0; i < NID; i++)
         if (!ret_valid && mdl_out[i] && ret_due[i] >= 0 && ret_due[i] <= now) begin
            ret_valid = 1'b1;
            ret_id    = ID_W'(i);
         end
      if (mdl_busy && !flush_exp && ($urandom_range(0, 99) < redirect_pct)) begin
         redirect_valid   = 1'b1;
         redirect_id      = ID_W'($urandom_range(0, NID - 1));
         redirect_address = ADDR_W'($urandom);
      end
   endtask

   // One clock: judge the coming edge from the current inputs, advance, check registered results.
   task automatic tick();
      logic            xfer, flush_now, do_cmd;
      logic [QW-1:0]   f;
      logic [ID_W-1:0] xid, rid;
      do_cmd = bus.cmd_valid && !mdl_busy;
      if (bus.out_valid) begin
         if (exp_q.size() == 0) check("spurious_valid", bus.out_valid, 0);
         else begin
            f = exp_q[0];
            check("req_address", bus.out_address, f[QW-1:ID_W]);
            check("req_id", bus.out_id, f[ID_W-1:0]);
            check("req_id_free", mdl_out[bus.out_id], 0);
         end
      end
      if (prev_hold) check("hold_valid", bus.out_valid, 1);
      flush_now = redirect_valid && mdl_busy;
      rid       = redirect_id;
      xfer      = bus.out_valid && !bus.in_stall && !flush_now && (exp_q.size() > 0);
      if (xfer) begin
         f = exp_q.pop_front();
         xid = f[ID_W-1:0];
         mdl_out[xid] = 1'b1;
         ret_due[xid] = (ret_hi >= 0) ? now + int'($urandom_range(ret_lo, ret_hi)) : -1;
         xfer_addr.push_back(f[QW-1:ID_W]);
         xfer_id.push_back(xid);
         if (first_xfer < 0) first_xfer = now;
         last_xfer = now;
      end
      if (ret_valid) begin
         if (!mdl_out[ret_id] && !(flush_now && rid == ret_id)) mdl_err = 1'b1;
         mdl_out[ret_id] = 1'b0;
         ret_due[ret_id] = -1;
      end
      if (flush_now) begin
         model_redirect(redirect_address);
         mdl_out[rid] = 1'b0;
         ret_due[rid] = -1;
      end
      prev_hold = bus.out_valid && bus.in_stall && !flush_now;
      if (do_cmd) begin
         model_cmd(bus.cmd_address, bus.cmd_stride, int'(bus.cmd_length));
         mdl_busy = 1'b1;
      end
      flush_exp = flush_now;
      @(posedge clk);
      @(negedge clk);
      now++;
      check("flush_pulse", bus.out_flush, flush_now);
      if (flush_now) begin
         check("flush_id", bus.out_flush_id, rid);
         check("flush_valid_low", bus.out_valid, 0);
      end
      check("err_retire", err_retire, mdl_err);
      if (done) begin
         done_cnt++;
         mdl_busy = 1'b0;
      end
   endtask

   task automatic start_cmd(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] s,
                            input int len);
      check("cmd_ready_idle", bus.cmd_ready, 1);
      auto_inputs();
      bus.cmd_valid   = 1'b1;
      bus.cmd_address = a;
      bus.cmd_stride  = s;
      bus.cmd_length  = LEN_W'(len);
      cur_len    = len;
      cur_stride = s;
      done_cnt   = 0;
      first_xfer = -1;
      cmd_tick   = now;
      xfer_addr.delete();
      xfer_id.delete();
      tick();
      bus.cmd_valid = 1'b0;
   endtask

   task automatic drain();
      int t = 0;
      while (mdl_busy && t < 4000) begin
         auto_inputs();
         tick();
         t++;
      end
      check("drain_done", 32'(mdl_busy), 0);
      check("xfer_count", xfer_addr.size(), cur_len);
      check("queue_empty", exp_q.size(), 0);
      check("busy_after_done", busy, 0);
      check("cmd_ready_after_done", bus.cmd_ready, 1);
      repeat (2) begin
         auto_inputs();
         tick();
      end
      check("done_once", done_cnt, 1);
   endtask

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      logic [ID_W-1:0] id0;
      n_tests = 0;
      n_fail  = 0;
      now     = 0;
      ret_lo = 1; ret_hi = 3; stall_pct = 0; redirect_pct = 0;
      bus.cmd_valid = 1'b0; bus.cmd_address = '0; bus.cmd_stride = '0; bus.cmd_length = '0;
      bus.in_stall = 1'b0;
      redirect_valid = 1'b0; redirect_id = '0; redirect_address = '0;
      ret_valid = 1'b0; ret_id = '0;
      model_reset();

      // reset state
      repeat (3) @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_cmd_ready", bus.cmd_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err_retire, 0);
      check("rst_flush", bus.out_flush, 0);
      check("rst_address", bus.out_address, 0);
      check("rst_id", bus.out_id, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // basic burst, retire 2 cycles after issue
      ret_lo = 2; ret_hi = 2;
      start_cmd(16'h0100, 16'd4, 3);
      drain();
      check("b1_addr0", xfer_addr[0], 16'h0100);
      check("b1_addr2", xfer_addr[2], 16'h0108);
      check("b1_id2", xfer_id[2], 2);
      check("b1_first_latency", first_xfer - cmd_tick, 1);
      check("b1_back_to_back", last_xfer - first_xfer, 2);

      // stall held for 3 cycles on the second request
      id0 = mdl_next_id;
      start_cmd(16'h0100, 16'd4, 3);
      auto_inputs(); bus.in_stall = 1'b0; tick();
      repeat (3) begin auto_inputs(); bus.in_stall = 1'b1; tick(); end
      drain();
      check("b2_addr1", xfer_addr[1], 16'h0104);
      check("b2_id1", xfer_id[1], ID_W'(id0 + ID_W'(1)));
      check("b2_id2", xfer_id[2], ID_W'(id0 + ID_W'(2)));

      // full bitmap blocks issue until the oldest id retires
      id0 = mdl_next_id;
      ret_hi = -1;
      start_cmd(16'h0300, 16'd2, 20);
      repeat (30) begin auto_inputs(); tick(); end
      check("full_xfers", xfer_addr.size(), NID);
      check("full_valid_low", bus.out_valid, 0);
      auto_inputs(); ret_valid = 1'b1; ret_id = id0; tick();
      check("reissue_valid", bus.out_valid, 1);
      check("reissue_addr", bus.out_address, 16'h0320);
      check("reissue_id", bus.out_id, id0);
      ret_lo = 1; ret_hi = 3;
      for (int i = 0; i < NID; i++) if (mdl_out[i]) ret_due[i] = now + 1 + i;
      drain();

      // redirect while the third request is held
      id0 = mdl_next_id;
      ret_lo = 10; ret_hi = 10;
      start_cmd(16'h0100, 16'd4, 5);
      auto_inputs(); bus.in_stall = 1'b0; tick();
      auto_inputs(); bus.in_stall = 1'b0; tick();
      auto_inputs(); bus.in_stall = 1'b1; tick();
      auto_inputs(); bus.in_stall = 1'b1;
      redirect_valid = 1'b1; redirect_id = ID_W'(id0 + ID_W'(1)); redirect_address = 16'h2000;
      tick();
      auto_inputs(); bus.in_stall = 1'b0; tick();
      check("redir_valid", bus.out_valid, 1);
      check("redir_addr", bus.out_address, 16'h2000);
      check("redir_id", bus.out_id, ID_W'(id0 + ID_W'(2)));
      ret_lo = 1; ret_hi = 3;
      drain();
      check("redir_addr3", xfer_addr[3], 16'h2004);

      // address wrap
      start_cmd(16'hFFFC, 16'd4, 2);
      drain();
      check("wrap_addr0", xfer_addr[0], 16'hFFFC);
      check("wrap_addr1", xfer_addr[1], 16'h0000);

      // empty burst
      start_cmd(16'h1234, 16'd1, 0);
      drain();

      // random bursts with stalls, retires and redirects
      for (int b = 0; b < 10; b++) begin
         stall_pct    = int'($urandom_range(0, 50));
         ret_lo       = 1;
         ret_hi       = int'($urandom_range(1, 8));
         redirect_pct = 4;
         start_cmd(ADDR_W'($urandom), ADDR_W'($urandom), int'($urandom_range(1, 24)));
         drain();
      end
      redirect_pct = 0;

      // bad retire is sticky, then asynchronous reset mid-burst
      stall_pct = 100; ret_hi = -1;
      id0 = mdl_next_id;
      start_cmd(16'h4000, 16'd8, 4);
      auto_inputs(); tick();
      auto_inputs(); ret_valid = 1'b1; ret_id = ID_W'(id0 + ID_W'(5)); tick();
      check("err_set", err_retire, 1);
      repeat (3) begin auto_inputs(); tick(); end
      check("err_sticky", err_retire, 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_valid", bus.out_valid, 0);
      check("arst_ready", bus.cmd_ready, 1);
      check("arst_err", err_retire, 0);
      check("arst_busy", busy, 0);
      check("arst_flush", bus.out_flush, 0);
      model_reset();
      ret_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      stall_pct = 0; ret_lo = 1; ret_hi = 3;
      start_cmd(16'h0040, 16'd16, 2);
      drain();
      check("post_rst_id0", xfer_id[0], 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
